// File: rtl/stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared definitions for the stack controller slice:
//   - state_t    : controller FSM states (ST_INIT_CLEAR, ST_READY)
//   - DEF_WIDTH  : default data word width
//   - DEF_DEPTH  : default number of stack entries
//   - ptr_width(): address width needed to index DEPTH entries
// -----------------------------------------------------------------------------
package stack_ctrl_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef enum logic {
      ST_INIT_CLEAR = 1'b0,
      ST_READY      = 1'b1
   } state_t;

   // Width of an index into a DEPTH-entry array; never less than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// Storage array for the stack: one synchronous write port, one combinational
// read port. Holds no sequencing logic of its own.
//
// Ports:
//   clk    in   clock
//   we     in   write enable (write on rising edge)
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module stack_mem
   import stack_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; contents are zeroed by the controller's
   // one-entry-per-cycle sweep, which keeps this mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_controller.sv
// -----------------------------------------------------------------------------
// stack_controller
// LIFO stack controller with a power-up / on-demand memory zeroing sweep.
// After reset or clear the FSM sits in ST_INIT_CLEAR (busy=1) for DEPTH
// cycles writing zero to each entry, then accepts push/pop in ST_READY.
//
// Ports:
//   clk       in   clock, all state updates on rising edge
//   reset     in   synchronous active-high reset
//   clear     in   flush stack and re-run the zeroing sweep
//   push      in   push request
//   pop       in   pop request
//   data_in   in   word to push (WIDTH bits)
//   data_out  out  registered popped word (WIDTH bits)
//   full      out  stack holds DEPTH words
//   empty     out  stack holds no words
//   count     out  current occupancy (clog2(DEPTH)+1 bits)
//   busy      out  zeroing sweep in progress
//   error     out  overflow / underflow / request-while-busy flag
//
// Configuration macro:
//   STACK_CTRL_ERR_STICKY_EN  when defined, error holds once set until reset
//                             or clear; otherwise error is a one-cycle pulse
//                             per offending request.
// -----------------------------------------------------------------------------
module stack_controller
   import stack_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic [ptr_width(DEPTH):0]  count,
   output logic                       busy,
   output logic                       error
);

   localparam int AW = ptr_width(DEPTH);

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;      // sweep index
   logic [AW:0]      sp_q, sp_d;        // stack pointer == occupancy
   logic [WIDTH-1:0] dout_d;
   logic             err_now;
   logic             err_d;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [AW-1:0]    mem_raddr;
   logic [WIDTH-1:0] mem_rdata;

   // Top-of-stack address. When sp==DEPTH the low bits wrap to 0, so
   // subtracting one still lands on DEPTH-1.
   assign mem_raddr = sp_q[AW-1:0] - 1'b1;

   assign count = sp_q;
   assign empty = (sp_q == '0);
   assign full  = (sp_q == (AW+1)'(DEPTH));
   assign busy  = (state_q == ST_INIT_CLEAR);

   stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we & ~reset),  // reset abandons any write issued this cycle
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      sp_d      = sp_q;
      dout_d    = data_out;
      err_now   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = idx_q;
      mem_wdata = '0;

      unique case (state_q)
         ST_INIT_CLEAR: begin
            if (clear) begin
               idx_d = '0;               // restart sweep, requests dropped
            end else begin
               mem_we  = 1'b1;           // zero one entry per cycle
               err_now = push | pop;     // requests are refused while busy
               idx_d   = idx_q + 1'b1;
               if (idx_q == AW'(DEPTH - 1)) begin
                  state_d = ST_READY;
               end
            end
         end

         ST_READY: begin
            if (clear) begin
               state_d = ST_INIT_CLEAR;
               idx_d   = '0;
               sp_d    = '0;
            end else if (push && pop) begin
               // Replace-top: return the old top and overwrite it in place.
               if (empty) begin
                  err_now = 1'b1;
               end else begin
                  dout_d    = mem_rdata;
                  mem_we    = 1'b1;
                  mem_waddr = mem_raddr;
                  mem_wdata = data_in;
               end
            end else if (push) begin
               if (full) begin
                  err_now = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = sp_q[AW-1:0];
                  mem_wdata = data_in;
                  sp_d      = sp_q + 1'b1;
               end
            end else if (pop) begin
               if (empty) begin
                  err_now = 1'b1;
               end else begin
                  dout_d = mem_rdata;
                  sp_d   = sp_q - 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_INIT_CLEAR;
            idx_d   = '0;
         end
      endcase

`ifdef STACK_CTRL_ERR_STICKY_EN
      err_d = clear ? 1'b0 : (error | err_now);
`else
      err_d = err_now;
`endif
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_INIT_CLEAR;
         idx_q    <= '0;
         sp_q     <= '0;
         data_out <= '0;
         error    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sp_q     <= sp_d;
         data_out <= dout_d;
         error    <= err_d;
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// -----------------------------------------------------------------------------
// tb_stack_controller
// Self-checking bench for stack_controller (default WIDTH=8, DEPTH=16).
// Stimulus updates a queue-based stack model and pushes the expected outputs
// into a scoreboard; a monitor pops one entry per cycle and compares.
// Honours STACK_CTRL_ERR_STICKY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_stack_controller;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             clear = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic [4:0]       count;
   logic             busy;
   logic             error;

   always #5 clk = ~clk;

   stack_controller #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .push     (push),
      .pop      (pop),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .busy     (busy),
      .error    (error)
   );

   typedef struct {
      logic [WIDTH-1:0] dout;
      logic             err;
      int               cnt;
      logic             bsy;
      string            tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Reference model: the stack is a queue whose back is the top.
   logic [WIDTH-1:0] m_stk[$];
   int               m_busy = 0;    // remaining busy cycles
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_err  = 1'b0;
   string            cur_tag = "reset";

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic model_step(input logic r, input logic c, input logic p,
                             input logic o, input logic [WIDTH-1:0] d);
      logic e_now;
      e_now = 1'b0;
      if (r) begin
         m_stk.delete();
         m_dout = '0;
         m_err  = 1'b0;
         m_busy = DEPTH;
         return;
      end
      if (m_busy > 0) begin
         if (c) m_busy = DEPTH;
         else begin
            m_busy--;
            e_now = p | o;
         end
      end else if (c) begin
         m_stk.delete();
         m_busy = DEPTH;
      end else if (p && o) begin
         if (m_stk.size() == 0) e_now = 1'b1;
         else begin
            m_dout = m_stk[m_stk.size()-1];
            m_stk[m_stk.size()-1] = d;
         end
      end else if (p) begin
         if (m_stk.size() == DEPTH) e_now = 1'b1;
         else m_stk.push_back(d);
      end else if (o) begin
         if (m_stk.size() == 0) e_now = 1'b1;
         else m_dout = m_stk.pop_back();
      end
`ifdef STACK_CTRL_ERR_STICKY_EN
      m_err = c ? 1'b0 : (m_err | e_now);
`else
      m_err = e_now;
`endif
   endtask

   // One clock of stimulus: drive, let the edge happen, record expectation.
   task automatic cyc(input logic r, input logic c, input logic p,
                      input logic o, input logic [WIDTH-1:0] d);
      exp_t e;
      reset = r; clear = c; push = p; pop = o; data_in = d;
      @(posedge clk);
      #1;
      model_step(r, c, p, o, d);
      e.dout = m_dout;
      e.err  = m_err;
      e.cnt  = m_stk.size();
      e.bsy  = (m_busy > 0);
      e.tag  = cur_tag;
      exp_q.push_back(e);
      reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic do_push(input logic [WIDTH-1:0] d);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, d);
   endtask

   task automatic do_pop();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 3 * DEPTH && m_busy > 0; i++) idle(1);
   endtask

   // Monitor: one scoreboard entry per cycle, compared at the falling edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, " data_out"}, int'(data_out), int'(e.dout));
            check({e.tag, " error"},    int'(error),    int'(e.err));
            check({e.tag, " count"},    int'(count),    e.cnt);
            check({e.tag, " busy"},     int'(busy),     int'(e.bsy));
            check({e.tag, " full"},     int'(full),     int'(e.cnt == DEPTH));
            check({e.tag, " empty"},    int'(empty),    int'(e.cnt == 0));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stimulus
      // Reset, then idle through the full sweep and beyond.
      cur_tag = "rst_idle";
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      idle(DEPTH + 4);

      // Basic LIFO order.
      cur_tag = "lifo";
      do_push(8'h11); do_push(8'h22); do_push(8'h33);
      do_pop(); do_pop();
      do_pop();

      // Fill to full, overflow, then pop the real top.
      cur_tag = "overflow";
      for (int i = 0; i < DEPTH; i++) do_push(8'(8'hC0 + i));
      do_push(8'hAA);
      idle(1);
      do_pop();

      // Drain, underflow, push+pop on empty.
      cur_tag = "underflow";
      for (int i = 0; i < DEPTH - 1; i++) do_pop();
      do_pop();
      idle(1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
      idle(1);

      // Replace-top.
      cur_tag = "replace";
      do_push(8'h10); do_push(8'h20);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
      do_pop(); do_pop();

      // Clear at count=5 with every entry non-zero beforehand.
      cur_tag = "clear";
      for (int i = 0; i < DEPTH; i++) do_push(8'(8'h81 + i));
      for (int i = 0; i < DEPTH - 5; i++) do_pop();
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      while (m_busy > 2) idle(1);
      do_push(8'hEE);
      wait_ready();
      for (int i = 0; i < DEPTH; i++)
         check($sformatf("clear mem[%0d]", i), int'(dut.u_mem.mem[i]), 0);
      do_pop();
      idle(1);

      // Clear during the sweep restarts it; reset mid-sweep too.
      cur_tag = "restart";
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      idle(5);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
      idle(7);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h44);
      wait_ready();

      // Randomized traffic: push-biased then pop-biased phases.
      cur_tag = "random";
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 300; i++) begin
            logic r, c, p, o;
            r = ($urandom_range(0, 249) == 0);
            c = ($urandom_range(0, 79) == 0);
            p = ($urandom_range(0, 99) < (ph == 0 ? 65 : 35));
            o = ($urandom_range(0, 99) < (ph == 0 ? 35 : 65));
            cyc(r, c, p, o, 8'($urandom));
         end
      end
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of entries; it SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 clear  input  1  SHALL request a stack flush and memory zeroing.
REQ-006 push  input  1  SHALL be a push request for the current cycle.
REQ-007 pop  input  1  SHALL be a pop request for the current cycle.
REQ-008 data_in  input  WIDTH  SHALL be the word to push.
REQ-009 data_out  output  WIDTH  SHALL be the registered popped word.
REQ-010 full, empty  output  1 each  SHALL be the stack-full and stack-empty flags.
REQ-011 count  output  clog2(DEPTH)+1  SHALL be the current occupancy.
REQ-012 busy  output  1  SHALL be high while a memory clear is in progress.
REQ-013 error  output  1  SHALL be the overflow/underflow/busy-violation flag.

Function
REQ-014 The FSM SHALL have two states: ST_INIT_CLEAR and ST_READY; busy SHALL be 1 exactly when the FSM is in ST_INIT_CLEAR.
REQ-015 ST_INIT_CLEAR SHALL write zero to one entry per cycle, from index 0 to DEPTH-1; after writing DEPTH-1 it SHALL go to ST_READY (busy held for exactly DEPTH cycles).
REQ-016 In ST_READY, clear SHALL move the FSM to ST_INIT_CLEAR at index 0 and set sp to 0; clear takes priority over push and pop in the same cycle, which are dropped with no error.
REQ-017 clear asserted in ST_INIT_CLEAR SHALL restart the sweep at index 0.
REQ-018 count SHALL equal sp; empty SHALL equal (sp==0) and full SHALL equal (sp==DEPTH), both combinational from sp.
REQ-019 Push only, not full: mem[sp] <= data_in and sp <= sp+1; data_out SHALL be unchanged.
REQ-020 Pop only, not empty: data_out <= mem[sp-1] and sp <= sp-1; the popped value SHALL be visible on data_out in the cycle after the request (latency 1).
REQ-021 Push and pop together, not empty: data_out <= mem[sp-1] and mem[sp-1] <= data_in; sp SHALL be unchanged (replace-top).
REQ-022 Push when full, pop when empty, or push+pop when empty: no memory, sp or data_out change, and an error SHALL be raised.
REQ-023 A push or pop in ST_INIT_CLEAR without clear SHALL be ignored and SHALL raise an error.
REQ-024 An error SHALL become visible on error in the cycle after the offending request.

Reset
REQ-025 On reset, the block SHALL set sp=0, data_out=0 and error=0, and enter ST_INIT_CLEAR at index 0 (busy=1 in the next cycle).
REQ-026 Reset SHALL override clear, push and pop, and SHALL abandon any in-progress sweep or operation.

Configuration
REQ-027 With STACK_CTRL_ERR_STICKY_EN defined, error SHALL stay high once set until reset or an accepted clear.
REQ-028 Without STACK_CTRL_ERR_STICKY_EN, error SHALL be a one-cycle pulse per offending request.

Structure
REQ-029 Package stack_ctrl_pkg SHALL hold the state enum (ST_INIT_CLEAR, ST_READY), the default WIDTH/DEPTH constants and the pointer-width helper.
REQ-030 Storage SHALL be a sub-module stack_mem with one synchronous write port and one combinational read port; all sequencing SHALL live in stack_controller.

Verification
REQ-031 Reset with no requests: busy=1 for exactly 16 cycles, then 0; count=0, empty=1, data_out=0x00.
REQ-032 After ready, push 0x11, 0x22, 0x33 on consecutive cycles, then pop twice: data_out=0x33 then 0x22, each one cycle after its pop; count=1.
REQ-033 Push 16 words: full=1; a 17th push with 0xAA gives error the next cycle and count stays 16; popping then returns the 16th word, not 0xAA.
REQ-034 Empty stack, pop: error=1 (pulse, or sticky under the macro), data_out unchanged; then push+pop of 0x5A on an empty stack: error, count=0.
REQ-035 Stack holding 0x10, 0x20: push+pop with 0x77 gives data_out=0x20 and count=2; a following pop gives data_out=0x77.
REQ-036 clear while count=5: busy for 16 cycles, count=0; a push during busy gives error and no write; a post-clear pop underflows; all entries read 0x00.
